// File: rtl/bcd_adder_unit_pkg.sv
// rtl/bcd_adder_unit_pkg.sv - shared BCD constants, digit type and range helper
//
// Purpose : constants and types common to the BCD adder files.
// Ports   : none (package bcd_pkg).
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_CORR    = 6;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // True when a digit is outside the decimal range 0..9.
  function automatic logic digit_over_max(input bcd_digit_t d);
    return d > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_adder_unit_if.sv
// rtl/bcd_adder_unit_if.sv - operand/result bundle for the BCD adder
//
// Purpose : groups the operand side (in_valid, a, b, cin) and result side
//           (sum, cout, out_valid, err) of the adder.
// Modports: master - drives operands, observes results.
//           slave  - the adder: receives operands, drives results.
interface bcd_adder_unit_if #(
  parameter int NUM_DIGITS = 1
);
  import bcd_pkg::*;

  localparam int W = NUM_DIGITS * BCD_DIGIT_W;

  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         err;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid, err
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid, err
  );

endinterface

// File: rtl/bcd_adder_unit_digit_add.sv
// rtl/bcd_adder_unit_digit_add.sv - combinational single-digit BCD adder
//
// Purpose : one decimal digit of the ripple chain.
// Ports   : a, b  - input digits (values 10..15 are processed by the same rule)
//           ci    - carry in
//           s     - corrected sum digit
//           co    - decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);

  logic [4:0] w_t;

  always_comb begin
    w_t = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    s   = w_t[3:0];
    co  = 1'b0;
    if (w_t > 5'(BCD_MAX)) begin
      // 4-bit add wraps, giving (t + 6) mod 16.
      s  = w_t[3:0] + 4'(BCD_CORR);
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_adder_unit.sv
// rtl/bcd_adder_unit.sv - NUM_DIGITS-digit packed BCD adder with registered result
//
// Purpose : ripple-carry BCD addition in one cycle, result registered with
//           one cycle latency; outputs hold while no input is accepted.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           io  - bcd_adder_unit_if.slave (in_valid, a, b, cin -> sum, cout,
//                 out_valid, err)
// Config  : BCD_ADDER_DIGIT_CHECK_EN - when defined, err flags any operand
//           digit above 9; otherwise err is tied low.
module bcd_adder_unit
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_adder_unit_if.slave io
);

  localparam int W = NUM_DIGITS * BCD_DIGIT_W;

  logic [NUM_DIGITS:0] w_carry;
  logic [W-1:0]        w_sum;
  logic [W-1:0]        r_sum;
  logic                r_cout;
  logic                r_valid;

  assign w_carry[0] = io.cin;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit_add u_digit (
      .a  (io.a[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .b  (io.b[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .ci (w_carry[gi]),
      .s  (w_sum[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .co (w_carry[gi+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= io.in_valid;
      if (io.in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[NUM_DIGITS];
      end
    end
  end

  assign io.sum       = r_sum;
  assign io.cout      = r_cout;
  assign io.out_valid = r_valid;

`ifdef BCD_ADDER_DIGIT_CHECK_EN
  logic w_range_err;
  logic r_err;

  always_comb begin
    w_range_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_over_max(io.a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          digit_over_max(io.b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        w_range_err = 1'b1;
    end
  end

  // Held alongside sum/cout so err always describes the displayed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if (io.in_valid)
      r_err <= w_range_err;
  end

  assign io.err = r_err;
`else
  assign io.err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_adder_unit.sv
// tb/tb_bcd_adder_unit.sv - self-checking bench for bcd_adder_unit (1 and 2 digits)
module tb_bcd_adder_unit;

`ifdef BCD_ADDER_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_adder_unit_if #(.NUM_DIGITS(1)) if1 ();
  bcd_adder_unit_if #(.NUM_DIGITS(2)) if2 ();

  bcd_adder_unit #(.NUM_DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .io(if1.slave));
  bcd_adder_unit #(.NUM_DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .io(if2.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: digit-by-digit decimal addition with the +6 correction rule.
  function automatic logic [32:0] ref_add(input int nd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    int c, t, d;
    logic [31:0] s;
    c = int'(cin);
    s = '0;
    for (int i = 0; i < nd; i++) begin
      t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (t > 9) begin d = (t + 6) % 16; c = 1; end
      else       begin d = t;            c = 0; end
      s = s | (32'(d) << (4*i));
    end
    return {c[0], s};
  endfunction

  function automatic logic [31:0] ref_sum(input int nd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] r;
    r = ref_add(nd, a, b, cin);
    return r[31:0];
  endfunction

  function automatic logic ref_cout(input int nd, input logic [31:0] a,
                                    input logic [31:0] b, input logic cin);
    logic [32:0] r;
    r = ref_add(nd, a, b, cin);
    return r[32];
  endfunction

  function automatic logic ref_err(input int nd, input logic [31:0] a, input logic [31:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < nd; i++)
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad & CHECK_EN;
  endfunction

  // Expected output state of each instance.
  logic [3:0] e1_sum = '0;
  logic       e1_cout = 1'b0, e1_err = 1'b0, e1_valid = 1'b0;
  logic [7:0] e2_sum = '0;
  logic       e2_cout = 1'b0, e2_err = 1'b0, e2_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_sum <= '0; e1_cout <= 1'b0; e1_err <= 1'b0; e1_valid <= 1'b0;
      e2_sum <= '0; e2_cout <= 1'b0; e2_err <= 1'b0; e2_valid <= 1'b0;
    end else begin
      e1_valid <= if1.in_valid;
      e2_valid <= if2.in_valid;
      if (if1.in_valid) begin
        e1_sum  <= 4'(ref_sum(1, 32'(if1.a), 32'(if1.b), if1.cin));
        e1_cout <= ref_cout(1, 32'(if1.a), 32'(if1.b), if1.cin);
        e1_err  <= ref_err(1, 32'(if1.a), 32'(if1.b));
      end
      if (if2.in_valid) begin
        e2_sum  <= 8'(ref_sum(2, 32'(if2.a), 32'(if2.b), if2.cin));
        e2_cout <= ref_cout(2, 32'(if2.a), 32'(if2.b), if2.cin);
        e2_err  <= ref_err(2, 32'(if2.a), 32'(if2.b));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("u1_sum",   32'(if1.sum),       32'(e1_sum));
    chk("u1_cout",  32'(if1.cout),      32'(e1_cout));
    chk("u1_err",   32'(if1.err),       32'(e1_err));
    chk("u1_valid", 32'(if1.out_valid), 32'(e1_valid));
    chk("u2_sum",   32'(if2.sum),       32'(e2_sum));
    chk("u2_cout",  32'(if2.cout),      32'(e2_cout));
    chk("u2_err",   32'(if2.err),       32'(e2_err));
    chk("u2_valid", 32'(if2.out_valid), 32'(e2_valid));
  end

  // Present one operand set to both instances, then step to just after the capture edge.
  task automatic drive(input logic [3:0] a1, input logic [3:0] b1, input logic c1,
                       input logic [7:0] a2, input logic [7:0] b2, input logic c2);
    if1.in_valid = 1'b1; if1.a = a1; if1.b = b1; if1.cin = c1;
    if2.in_valid = 1'b1; if2.a = a2; if2.b = b2; if2.cin = c2;
    @(posedge clk); #3;
  endtask

  task automatic lit1(input string name, input logic [3:0] s, input logic co);
    chk({name, "_sum"},   32'(if1.sum),       32'(s));
    chk({name, "_cout"},  32'(if1.cout),      32'(co));
    chk({name, "_valid"}, 32'(if1.out_valid), 32'd1);
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_sum",   32'(if1.sum),       32'd0);
    chk("rst_valid", 32'(if1.out_valid), 32'd0);
    rst = 1'b0;

    drive(4'd0, 4'd0, 1'b0, 8'h99, 8'h01, 1'b0);
    lit1("a0b0", 4'd0, 1'b0);
    chk("d2_ripple_sum",  32'(if2.sum),  32'h00);
    chk("d2_ripple_cout", 32'(if2.cout), 32'd1);

    drive(4'd6, 4'd9, 1'b0, 8'h45, 8'h54, 1'b0);
    lit1("a6b9", 4'd5, 1'b1);
    chk("d2_99_sum", 32'(if2.sum), 32'h99);

    drive(4'd3, 4'd3, 1'b1, 8'h38, 8'h27, 1'b0);
    lit1("a3b3c1", 4'd7, 1'b0);
    chk("d2_65_sum", 32'(if2.sum), 32'h65);

    drive(4'd4, 4'd5, 1'b0, 8'h00, 8'h00, 1'b0);
    lit1("a4b5", 4'd9, 1'b0);
    drive(4'd8, 4'd2, 1'b0, 8'h00, 8'h00, 1'b1);
    lit1("a8b2", 4'd0, 1'b1);
    drive(4'd9, 4'd9, 1'b1, 8'h99, 8'h99, 1'b1);
    lit1("a9b9c1", 4'd9, 1'b1);
    chk("d2_max_sum",  32'(if2.sum),  32'h99);
    chk("d2_max_cout", 32'(if2.cout), 32'd1);

    // Non-decimal digit: 12 + 1 = 13 -> (13 + 6) mod 16 = 3, carry 1.
    drive(4'd12, 4'd1, 1'b0, 8'h0C, 8'h01, 1'b0);
    lit1("a12b1", 4'd3, 1'b1);
    chk("a12b1_err", 32'(if1.err), 32'(CHECK_EN));
    chk("d2_nonbcd_sum", 32'(if2.sum), 32'h13);

    // Idle with changing operands: results must hold.
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if1.a = 4'(i + 1); if1.b = 4'd9; if2.a = 8'h77;
      @(posedge clk); #3;
      chk("hold_sum",   32'(if1.sum),       32'd3);
      chk("hold_cout",  32'(if1.cout),      32'd1);
      chk("hold_valid", 32'(if1.out_valid), 32'd0);
    end

    drive(4'd1, 4'd2, 1'b0, 8'h12, 8'h34, 1'b0);
    lit1("bb0", 4'd3, 1'b0);
    drive(4'd5, 4'd5, 1'b0, 8'h50, 8'h50, 1'b0);
    lit1("bb1", 4'd0, 1'b1);
    drive(4'd7, 4'd8, 1'b1, 8'h07, 8'h08, 1'b1);
    lit1("bb2", 4'd6, 1'b1);
    drive(4'd0, 4'd9, 1'b1, 8'h90, 8'h09, 1'b1);
    lit1("bb3", 4'd0, 1'b1);

    // Reset mid-cycle with an input pending: outputs clear at once, input is lost.
    drive(4'd6, 4'd9, 1'b0, 8'h45, 8'h54, 1'b0);
    if1.a = 4'd2; if1.b = 4'd2;
    rst = 1'b1;
    #1;
    chk("arst_sum",   32'(if1.sum),       32'd0);
    chk("arst_cout",  32'(if1.cout),      32'd0);
    chk("arst_valid", 32'(if1.out_valid), 32'd0);
    chk("arst_err",   32'(if1.err),       32'd0);
    chk("arst_sum2",  32'(if2.sum),       32'd0);
    @(posedge clk); #3;
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #3;
      chk("post_rst_valid", 32'(if1.out_valid), 32'd0);
      chk("post_rst_sum",   32'(if1.sum),       32'd0);
    end

    // Randomised traffic, mostly decimal digits with occasional 10..15.
    repeat (400) begin
      if1.in_valid = ($urandom_range(0, 3) != 0);
      if2.in_valid = ($urandom_range(0, 3) != 0);
      if1.a = 4'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      if1.b = 4'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      if1.cin = 1'($urandom_range(0, 1));
      for (int d = 0; d < 2; d++) begin
        if2.a[4*d +: 4] = 4'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
        if2.b[4*d +: 4] = 4'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      end
      if2.cin = 1'($urandom_range(0, 1));
      @(posedge clk); #3;
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
